// File: rtl/compositor_pkg.sv
// Shared types, colour constants and ROM art for the sprite compositor.
// Sprite and tile art are closed-form functions so each ROM has fixed, reproducible contents.
package compositor_pkg;

   localparam int PIX_W = 4;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t SKY_RGB    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
   localparam rgb_t GROUND_RGB = '{r: 8'hFF, g: 8'hCC, b: 8'h66};
   localparam logic [PIX_W-1:0] TRANSPARENT_IDX = '0;

   localparam logic [0:15][23:0] PALETTE = {
      24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
      24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF,
      24'h800000, 24'h008000, 24'h000080, 24'h808000,
      24'h800080, 24'h008080, 24'hC0C0C0, 24'h404040
   };

   function automatic rgb_t pal_lookup(input logic [PIX_W-1:0] idx);
      return rgb_t'(PALETTE[idx]);
   endfunction

   // Diagonal stripe per channel and animation frame; index 0 gives the transparent holes.
   function automatic logic [PIX_W-1:0] spr_pixel(input int ch, input int frame,
                                                  input int row, input int col);
      return PIX_W'(row + col + 5 * frame + 7 * ch + 3);
   endfunction

   function automatic logic [PIX_W-1:0] bg_pixel(input int row, input int col);
      return PIX_W'((row >> 3) ^ (col >> 3));
   endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: per-frame shadow state, animation counters, hit/address
// stage and a synchronous sprite ROM. Output idx/hit lag DrawX/DrawY by two cycles.
module sprite_channel
   import compositor_pkg::*;
#(
   parameter int CH         = 0,
   parameter int SPR_LOG2   = 4,
   parameter int NUM_FRAMES = 4,
   parameter int ANIM_DIV   = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             frame_tick,
   input  logic [9:0]       draw_x,
   input  logic [9:0]       draw_y,
   input  logic [9:0]       x,
   input  logic [9:0]       y,
   input  logic             en,
   input  logic             flip,
   input  logic             anim,
   output logic [PIX_W-1:0] idx,
   output logic             hit
);

   localparam int FW = $clog2(NUM_FRAMES);
   localparam int DW = $clog2(ANIM_DIV);
   localparam int AW = FW + 2 * SPR_LOG2;

   logic [9:0]          x_reg, y_reg;
   logic                en_reg, flip_reg;
   logic [FW-1:0]       frame_reg;
   logic [DW-1:0]       div_reg;
   logic [9:0]          dx, dy;
   logic [SPR_LOG2-1:0] col;
   logic                hit_next;
   logic [AW-1:0]       addr_next, addr_reg;
   logic                hit_s1_reg;

   // Shadow copy and animation advance only at frame_tick, so a pixel sampled
   // in the same cycle still sees the previous frame's state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_reg     <= '0;
         y_reg     <= '0;
         en_reg    <= 1'b0;
         flip_reg  <= 1'b0;
         frame_reg <= '0;
         div_reg   <= '0;
      end else if (frame_tick) begin
         x_reg    <= x;
         y_reg    <= y;
         en_reg   <= en;
         flip_reg <= flip;
         if (anim) begin
            if (div_reg == DW'(ANIM_DIV - 1)) begin
               div_reg   <= '0;
               frame_reg <= frame_reg + FW'(1);
            end else begin
               div_reg <= div_reg + DW'(1);
            end
         end
      end
   end

   // Unsigned 10-bit differences make left/top clipping fall out of the range test.
   always_comb begin
      dx        = draw_x - x_reg;
      dy        = draw_y - y_reg;
      hit_next  = en_reg && (dx[9:SPR_LOG2] == '0) && (dy[9:SPR_LOG2] == '0);
      col       = flip_reg ? ~dx[SPR_LOG2-1:0] : dx[SPR_LOG2-1:0];
      addr_next = {frame_reg, dy[SPR_LOG2-1:0], col};
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hit_s1_reg <= 1'b0;
         hit        <= 1'b0;
      end else begin
         hit_s1_reg <= hit_next;
         hit        <= hit_s1_reg;
      end
   end

   always_ff @(posedge Clk) begin
      addr_reg <= addr_next;
      idx      <= spr_pixel(CH, int'(addr_reg[AW-1 -: FW]),
                            int'(addr_reg[2*SPR_LOG2-1 -: SPR_LOG2]),
                            int'(addr_reg[SPR_LOG2-1:0]));
   end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage pixel compositor: sprite channels over sky/ground bands over a tiled
// background, with registered RGB, out_valid and winning-sprite id.
module sprite_compositor
   import compositor_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int SPR_LOG2    = 4,
   parameter int NUM_FRAMES  = 4,
   parameter int ANIM_DIV    = 8,
   parameter int BG_LOG2     = 7,
   localparam int HW         = $clog2(NUM_SPRITES) + 1
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      pix_valid,
   input  logic [9:0]                DrawX,
   input  logic [9:0]                DrawY,
   input  logic                      frame_tick,
   input  logic [9:0]                sky,
   input  logic [9:0]                ground,
   input  logic [NUM_SPRITES*10-1:0] spr_x,
   input  logic [NUM_SPRITES*10-1:0] spr_y,
   input  logic [NUM_SPRITES-1:0]    spr_en,
   input  logic [NUM_SPRITES-1:0]    spr_flip,
   input  logic [NUM_SPRITES-1:0]    spr_anim,
   output logic [7:0]                VGA_R,
   output logic [7:0]                VGA_G,
   output logic [7:0]                VGA_B,
   output logic                      out_valid,
   output logic [HW-1:0]             hit_id
);

   logic [PIX_W-1:0]     ch_idx [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] ch_hit;

   for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_ch
      sprite_channel #(
         .CH(gi), .SPR_LOG2(SPR_LOG2), .NUM_FRAMES(NUM_FRAMES), .ANIM_DIV(ANIM_DIV)
      ) u_ch (
         .Clk        (Clk),
         .Reset      (Reset),
         .frame_tick (frame_tick),
         .draw_x     (DrawX),
         .draw_y     (DrawY),
         .x          (spr_x[10*gi +: 10]),
         .y          (spr_y[10*gi +: 10]),
         .en         (spr_en[gi]),
         .flip       (spr_flip[gi]),
         .anim       (spr_anim[gi]),
         .idx        (ch_idx[gi]),
         .hit        (ch_hit[gi])
      );
   end

   logic                   valid_s1_reg, valid_s2_reg;
   logic                   sky_s1_reg, sky_s2_reg, gnd_s1_reg, gnd_s2_reg;
   logic [2*BG_LOG2-1:0]   bg_addr_reg;
   logic [PIX_W-1:0]       bg_idx_reg;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid_s1_reg <= 1'b0;
         valid_s2_reg <= 1'b0;
         sky_s1_reg   <= 1'b0;
         sky_s2_reg   <= 1'b0;
         gnd_s1_reg   <= 1'b0;
         gnd_s2_reg   <= 1'b0;
      end else begin
         valid_s1_reg <= pix_valid;
         valid_s2_reg <= valid_s1_reg;
         sky_s1_reg   <= (DrawY <= sky);
         sky_s2_reg   <= sky_s1_reg;
         gnd_s1_reg   <= (DrawY >= ground);
         gnd_s2_reg   <= gnd_s1_reg;
      end
   end

   always_ff @(posedge Clk) begin
      bg_addr_reg <= {DrawY[BG_LOG2-1:0], DrawX[BG_LOG2-1:0]};
      bg_idx_reg  <= bg_pixel(int'(bg_addr_reg[2*BG_LOG2-1 -: BG_LOG2]),
                              int'(bg_addr_reg[BG_LOG2-1:0]));
   end

   logic             win_found;
   logic [HW-1:0]    win_id;
   logic [PIX_W-1:0] win_idx;
   rgb_t             color_next;

   // Scan from the lowest-priority channel up so channel 0 overrides last.
   always_comb begin
      win_found = 1'b0;
      win_id    = '1;
      win_idx   = TRANSPARENT_IDX;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (ch_hit[i] && ch_idx[i] != TRANSPARENT_IDX) begin
            win_found = 1'b1;
            win_id    = HW'(i);
            win_idx   = ch_idx[i];
         end
      end
      if (win_found)       color_next = pal_lookup(win_idx);
      else if (sky_s2_reg) color_next = SKY_RGB;
      else if (gnd_s2_reg) color_next = GROUND_RGB;
      else                 color_next = pal_lookup(bg_idx_reg);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         VGA_R     <= '0;
         VGA_G     <= '0;
         VGA_B     <= '0;
         out_valid <= 1'b0;
         hit_id    <= '1;
      end else begin
         out_valid <= valid_s2_reg;
         if (valid_s2_reg) begin
            VGA_R  <= color_next.r;
            VGA_G  <= color_next.g;
            VGA_B  <= color_next.b;
            hit_id <= win_id;
         end else begin
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            hit_id <= '1;
         end
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed plus randomized bench for sprite_compositor against a frame-level
// reference model of layering, shadowing and animation.
module tb_sprite_compositor;

   localparam int NS = 4;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic             Reset = 1'b1, pix_valid = 1'b0, frame_tick = 1'b0;
   logic [9:0]       DrawX = '0, DrawY = '0, sky = '0, ground = '0;
   logic [NS*10-1:0] spr_x = '0, spr_y = '0;
   logic [NS-1:0]    spr_en = '0, spr_flip = '0, spr_anim = '0;
   logic [7:0]       VGA_R, VGA_G, VGA_B;
   logic             out_valid;
   logic [2:0]       hit_id;

   sprite_compositor dut (
      .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
      .frame_tick(frame_tick), .sky(sky), .ground(ground), .spr_x(spr_x), .spr_y(spr_y),
      .spr_en(spr_en), .spr_flip(spr_flip), .spr_anim(spr_anim),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .out_valid(out_valid), .hit_id(hit_id)
   );

   typedef struct packed {
      logic [23:0] rgb;
      logic [2:0]  hit;
      logic        valid;
      logic        chk_hit;
      logic [9:0]  x;
      logic [9:0]  y;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0, n_pass = 0;

   // Live inputs (what software writes) and model shadow state (what the frame uses).
   int lx[NS], ly[NS];
   bit len[NS], lflip[NS], lanim[NS];
   int lsky = 20, lgnd = 400;
   int sx[NS], sy[NS], ticks[NS];
   bit sen[NS], sflip[NS];

   logic [23:0] pal [16] = '{
      24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
      24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF,
      24'h800000, 24'h008000, 24'h000080, 24'h808000,
      24'h800080, 24'h008080, 24'hC0C0C0, 24'h404040
   };

   function automatic int art(int s, int f, int r, int c);
      return (r + c + 5 * f + 7 * s + 3) % 16;
   endfunction

   function automatic int bgart(int x, int y);
      return ((x % 128) / 8) ^ ((y % 128) / 8);
   endfunction

   function automatic exp_t model_pixel(int x, int y, bit v);
      exp_t e;
      e.x = 10'(x); e.y = 10'(y); e.valid = v; e.chk_hit = v;
      e.rgb = 24'h0; e.hit = 3'h7;
      if (!v) return e;
      for (int s = 0; s < NS; s++) begin
         int dx, dy, c, idx;
         dx = (x - sx[s] + 1024) % 1024;
         dy = (y - sy[s] + 1024) % 1024;
         if (sen[s] && dx < 16 && dy < 16) begin
            c   = sflip[s] ? 15 - dx : dx;
            idx = art(s, (ticks[s] / 8) % 4, dy, c);
            if (idx != 0) begin
               e.rgb = pal[idx];
               e.hit = 3'(s);
               return e;
            end
         end
      end
      if (y <= lsky)      e.rgb = 24'h00FFFF;
      else if (y >= lgnd) e.rgb = 24'hFFCC66;
      else                e.rgb = pal[bgart(x, y)];
      return e;
   endfunction

   task automatic model_tick();
      for (int s = 0; s < NS; s++) begin
         sx[s] = lx[s]; sy[s] = ly[s]; sen[s] = len[s]; sflip[s] = lflip[s];
         if (lanim[s]) ticks[s]++;
      end
   endtask

   task automatic check_pop();
      exp_t e;
      if (q.size() < 3) return;
      e = q.pop_front();
      n_checks++;
      assert ({VGA_R, VGA_G, VGA_B} === e.rgb) n_pass++;
      else $error("FAIL rgb (%0d,%0d) got %06h expected %06h", e.x, e.y, {VGA_R, VGA_G, VGA_B}, e.rgb);
      n_checks++;
      assert (out_valid === e.valid) n_pass++;
      else $error("FAIL out_valid (%0d,%0d) got %b expected %b", e.x, e.y, out_valid, e.valid);
      if (e.chk_hit) begin
         n_checks++;
         assert (hit_id === e.hit) n_pass++;
         else $error("FAIL hit_id (%0d,%0d) got %0d expected %0d", e.x, e.y, hit_id, e.hit);
      end
      if (e.valid) $display("px (%0d,%0d) rgb=%06h hit=%0d", e.x, e.y, {VGA_R, VGA_G, VGA_B}, hit_id);
   endtask

   task automatic drive(int x, int y, bit v, bit tick);
      @(negedge Clk);
      check_pop();
      Reset = 1'b0; DrawX = 10'(x); DrawY = 10'(y); pix_valid = v; frame_tick = tick;
      sky = 10'(lsky); ground = 10'(lgnd);
      for (int s = 0; s < NS; s++) begin
         spr_x[10*s +: 10] = 10'(lx[s]);
         spr_y[10*s +: 10] = 10'(ly[s]);
         spr_en[s] = len[s]; spr_flip[s] = lflip[s]; spr_anim[s] = lanim[s];
      end
   endtask

   task automatic cyc(int x, int y, bit v, bit tick);
      drive(x, y, v, tick);
      q.push_back(model_pixel(x, y, v));
      if (tick) model_tick();
   endtask

   // Valid pixel whose expected colour/hit are worked out by hand.
   task automatic cyc_lit(int x, int y, bit tick, logic [23:0] rgb, logic [2:0] hit);
      exp_t e;
      drive(x, y, 1'b1, tick);
      e.x = 10'(x); e.y = 10'(y); e.valid = 1'b1; e.chk_hit = 1'b1; e.rgb = rgb; e.hit = hit;
      q.push_back(e);
      if (tick) model_tick();
   endtask

   task automatic do_reset(int n);
      exp_t e;
      @(negedge Clk);
      Reset = 1'b1; pix_valid = 1'b0; frame_tick = 1'b0;
      repeat (n) @(posedge Clk);
      q.delete();
      e = '0; e.hit = 3'h7; e.chk_hit = 1'b1;
      q.push_back(e);
      e.chk_hit = 1'b0;
      q.push_back(e);
      q.push_back(e);
      for (int s = 0; s < NS; s++) begin
         sx[s] = 0; sy[s] = 0; sen[s] = 0; sflip[s] = 0; ticks[s] = 0;
      end
   endtask

   initial begin
      for (int s = 0; s < NS; s++) begin
         lx[s] = 0; ly[s] = 0; len[s] = 0; lflip[s] = 0; lanim[s] = 0;
      end
      do_reset(5);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      // Single sprite, opaque pixel and just past its right edge.
      lx[0] = 100; ly[0] = 50; len[0] = 1;
      cyc(0, 0, 0, 1);
      cyc_lit(100, 50, 0, 24'h00FF00, 3'd0);
      cyc_lit(116, 50, 0, 24'h800000, 3'd7);
      cyc(115, 65, 1, 0);

      // Priority and transparency.
      lx[0] = 200; ly[0] = 200; lx[1] = 200; ly[1] = 200; len[1] = 1;
      cyc(0, 0, 0, 1);
      cyc_lit(200, 200, 0, 24'h00FF00, 3'd0);
      cyc_lit(213, 200, 0, 24'h00FFFF, 3'd1);

      // Flip, left clip through wrap, right edge without wrap.
      lx[0] = 0; ly[0] = 0; lflip[0] = 1;
      cyc(0, 0, 0, 1);
      cyc_lit(0, 0, 0, 24'hFF0000, 3'd0);
      lx[0] = 1020; lflip[0] = 0;
      cyc(0, 0, 0, 1);
      cyc_lit(2, 0, 0, 24'h008000, 3'd0);
      cyc_lit(1019, 0, 0, 24'h00FFFF, 3'd7);
      cyc(1023, 5, 1, 0);
      lx[0] = 630;
      cyc(0, 0, 0, 1);
      cyc_lit(2, 0, 0, 24'h00FFFF, 3'd7);
      cyc_lit(639, 0, 0, 24'h800080, 3'd0);

      // Mid-frame update is invisible until frame_tick; coincident tick uses old state.
      lx[0] = 300; ly[0] = 100;
      cyc(0, 0, 0, 1);
      cyc_lit(300, 100, 0, 24'h00FF00, 3'd0);
      lx[0] = 400;
      cyc_lit(300, 100, 0, 24'h00FF00, 3'd0);
      cyc_lit(400, 100, 1, 24'hC0C0C0, 3'd7);
      cyc_lit(400, 100, 0, 24'h00FF00, 3'd0);
      cyc_lit(300, 100, 0, 24'h008000, 3'd7);

      // Bands and their boundaries.
      cyc_lit(50, 10, 0, 24'h00FFFF, 3'd7);
      cyc_lit(50, 20, 0, 24'h00FFFF, 3'd7);
      cyc(50, 21, 1, 0);
      cyc_lit(50, 400, 0, 24'hFFCC66, 3'd7);
      cyc_lit(50, 450, 0, 24'hFFCC66, 3'd7);

      // Animation: 8 ticks per frame, wrap after 32, hold when stopped.
      lx[2] = 500; ly[2] = 300; len[2] = 1; lanim[2] = 1;
      repeat (4) cyc(0, 0, 0, 1);
      cyc(500, 300, 1, 0);
      repeat (4) cyc(0, 0, 0, 1);
      cyc_lit(500, 300, 0, 24'hFF00FF, 3'd2);
      repeat (23) cyc(0, 0, 0, 1);
      cyc(500, 300, 1, 0);
      cyc(0, 0, 0, 1);
      cyc_lit(500, 300, 0, 24'hFFFFFF, 3'd2);
      lanim[2] = 0;
      repeat (8) cyc(0, 0, 0, 1);
      cyc_lit(500, 300, 0, 24'hFFFFFF, 3'd2);

      // Reset in the middle of a line flushes the pipeline and the shadows.
      cyc(500, 300, 1, 0);
      cyc(501, 300, 1, 0);
      do_reset(2);
      cyc(500, 300, 1, 0);
      cyc(401, 101, 1, 0);
      cyc(0, 0, 0, 0);

      // Randomized stream around a small window so sprites overlap often.
      for (int n = 0; n < 400; n++) begin
         int s;
         if ($urandom_range(0, 7) == 0) begin
            s = $urandom_range(0, NS - 1);
            lx[s] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 60);
            ly[s] = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 60);
            len[s] = 1'($urandom_range(0, 3) != 0);
            lflip[s] = 1'($urandom_range(0, 1));
            lanim[s] = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 31) == 0) begin
            lsky = $urandom_range(0, 30);
            lgnd = $urandom_range(40, 100);
         end
         cyc($urandom_range(0, 79), $urandom_range(0, 79),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      end

      repeat (3) cyc(0, 0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
